wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writer-side partner of the register file: owns the single regfile write port (waddr/wdata/we).
- Merges two sources onto that port:
  - in-order pipeline write-back, which has highest priority and no backpressure;
  - a long-latency unit (divider/load miss) with a valid/ready handshake, buffered in a small FIFO.
- Reports pending FIFO writes so ID can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  pipeline write-back valid.
- pipe_waddr  in  AW  pipeline destination register.
- pipe_wdata  in  DW  pipeline write data.
- ext_valid  in  1  long-latency result valid.
- ext_ready  out  1  arbiter can accept an ext write.
- ext_waddr  in  AW  long-latency destination register.
- ext_wdata  in  DW  long-latency data.
- we  out  1  regfile write enable (registered).
- waddr  out  AW  regfile write address (registered).
- wdata  out  DW  regfile write data (registered).
- pend_raddr1  in  AW  ID read address 1 to check.
- pend_raddr2  in  AW  ID read address 2 to check.
- pend_hit1  out  1  pend_raddr1 has a live FIFO entry.
- pend_hit2  out  1  pend_raddr2 has a live FIFO entry.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, while rst=1):
  - we=0, waddr=0, wdata=0, fifo_count=0, ext_ready=0, pend_hit1/2=0;
  - all entry live bits cleared; read/write pointers set to 0.
- Reset mid-operation discards all buffered writes; no partial write reaches the regfile.
- ext_ready = !rst && (fifo_count < DEPTH). It depends on the count before any same-cycle pop, so there is no push when full even if a pop occurs.
- Accept = ext_valid && ext_ready at an edge.
  - Accepted with ext_waddr != 0: enqueue {addr, data, live=1} at the tail.
  - Accepted with ext_waddr == 0: the handshake completes but nothing is enqueued.
- Pipeline write counts as active only if pipe_we=1 && pipe_waddr != 0. A write to $0 is treated as idle.
- Output register update at each edge, in priority order:
  1. pipeline active: we<=1, waddr<=pipe_waddr, wdata<=pipe_wdata.
  2. else FIFO non-empty: pop head; if head live, we<=1 with head addr/data; if head killed, we<=0 (entry discarded, one cycle spent).
  3. else: we<=0; waddr/wdata hold their previous values.
- Kill rule: a pipeline write is younger than any buffered ext write.
  - When the pipeline is active with address A, every FIFO entry with address A gets live<=0 at that edge.
  - This includes an entry being enqueued at the same edge with address A.
  - Killed entries still occupy a slot until popped.
- Simultaneous push and pop: both happen; fifo_count unchanged.
- Pointers wrap modulo DEPTH.
- pend_hitN (combinational) = pend_raddrN != 0 && any live entry address == pend_raddrN.
  - The entry currently in the output register is excluded, because the regfile forwards the same-cycle write.
- Latency, ext accept at edge E with the FIFO empty and no pipeline traffic:
  - the entry pops at E+1;
  - we=1 during the cycle after E+1.
- Starvation: continuous pipeline activity blocks the drain indefinitely, by design. When the FIFO is full, ext_ready stays 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined: if at edge E an accept occurs with ext_waddr != 0, the FIFO is empty and the pipeline is inactive, the write loads the output register directly at E (we=1 in the cycle after E). It is not enqueued and fifo_count stays 0.
- When undefined: all ext writes go through the FIFO, with a minimum of 2 edges from accept to we.

Test Plan:
- Reset then idle -> we=0, ext_ready=1, fifo_count=0; assert rst with 2 entries queued -> fifo_count=0 and we=0 immediately.
- Single ext write r5=0x1234, no pipeline traffic -> we=1, waddr=5, wdata=0x1234 one edge after the pop (2 edges after accept); with WB_BYPASS_EN, 1 edge after accept.
- Pipeline writes r1..r6 on consecutive cycles while ext pushes r9=0xA, r10=0xB -> regfile sees r1..r6 first, then r9, then r10; fifo_count peaks at 2.
- Push 4 ext writes with the pipeline busy (DEPTH=4) -> ext_ready=0 with fifo_count=4; a fifth ext_valid is held and accepted only after the first pop.
- Queue ext r7=0x1, then pipeline writes r7=0x2 -> entry killed; regfile r7 final value 0x2, one idle drain cycle with we=0; pend_hit for r7 drops after the kill.
- Ext write to r0, and a pipeline write to r0 alongside a queued r3 entry -> r0 write consumed with no enqueue; r3 drains in that cycle; pend_raddr1=0 never hits.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle: pipeline write-back, long-latency handshake,
// the registered regfile write, and the ID-stage pending-write lookup.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          ext_valid;
  logic          ext_ready;
  logic [AW-1:0] ext_waddr;
  logic [DW-1:0] ext_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] pend_raddr1;
  logic [AW-1:0] pend_raddr2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic [CW-1:0] fifo_count;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, ext_valid, ext_waddr, ext_wdata,
           pend_raddr1, pend_raddr2,
    input  ext_ready, we, waddr, wdata, pend_hit1, pend_hit2, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, ext_valid, ext_waddr, ext_wdata,
           pend_raddr1, pend_raddr2,
    output ext_ready, we, waddr, wdata, pend_hit1, pend_hit2, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter: pipeline write-back wins, long-latency writes drain
// from a small FIFO. Optional macro WB_BYPASS_EN lets an ext write skip an empty FIFO.

// One FIFO slot: storage, kill-on-younger-write, and pending-read compare.
module wb_arb_entry #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          wr_live,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr,
  input  logic          kill,
  input  logic [AW-1:0] kill_addr,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          live,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          hit1,
  output logic          hit2
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (wr) begin
      live <= wr_live;
      addr <= wr_addr;
      data <= wr_data;
    end else if (clr) begin
      // popped slot now sits in the output register; regfile forwarding covers it
      live <= 1'b0;
    end else if (kill && addr == kill_addr) begin
      live <= 1'b0;
    end
  end

  assign hit1 = live && (addr == raddr1);
  assign hit2 = live && (addr == raddr2);
endmodule

module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst,
  wb_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          pipe_act, ext_rdy, accept, push, pop, byp, enq_live;
  wr_t           pipe_req, ext_req, head, out_q;
  logic          head_live, we_q;

  logic [DEPTH-1:0]         e_live, wr_sel, clr_sel, hit1_v, hit2_v;
  logic [DEPTH-1:0][AW-1:0] e_addr;
  logic [DEPTH-1:0][DW-1:0] e_data;

  assign pipe_req = '{addr: bus.pipe_waddr, data: bus.pipe_wdata};
  assign ext_req  = '{addr: bus.ext_waddr,  data: bus.ext_wdata};

  // $0 writes are no-ops on both sources
  assign pipe_act = bus.pipe_we && (pipe_req.addr != '0);
  assign ext_rdy  = !rst && (count < FULL);
  assign accept   = bus.ext_valid && ext_rdy;
  assign pop      = !pipe_act && (count != '0);

`ifdef WB_BYPASS_EN
  assign byp = accept && (ext_req.addr != '0) && (count == '0) && !pipe_act;
`else
  assign byp = 1'b0;
`endif

  assign push = accept && (ext_req.addr != '0) && !byp;
  // pipeline write is younger: an entry to the same register arrives already dead
  assign enq_live = !(pipe_act && ext_req.addr == pipe_req.addr);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign wr_sel[i]  = push && (wptr == PW'(i));
      assign clr_sel[i] = pop  && (rptr == PW'(i));

      wb_arb_entry #(.AW(AW), .DW(DW)) u_ent (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr_sel[i]),
        .wr_live   (enq_live),
        .wr_addr   (ext_req.addr),
        .wr_data   (ext_req.data),
        .clr       (clr_sel[i]),
        .kill      (pipe_act),
        .kill_addr (pipe_req.addr),
        .raddr1    (bus.pend_raddr1),
        .raddr2    (bus.pend_raddr2),
        .live      (e_live[i]),
        .addr      (e_addr[i]),
        .data      (e_data[i]),
        .hit1      (hit1_v[i]),
        .hit2      (hit2_v[i])
      );
    end
  endgenerate

  assign head_live = e_live[rptr];
  assign head      = '{addr: e_addr[rptr], data: e_data[rptr]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else if (pipe_act) begin
      we_q  <= 1'b1;
      out_q <= pipe_req;
    end else if (pop) begin
      // a killed head still costs one idle write cycle
      we_q <= head_live;
      if (head_live) out_q <= head;
    end else if (byp) begin
      we_q  <= 1'b1;
      out_q <= ext_req;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign bus.ext_ready  = ext_rdy;
  assign bus.we         = we_q;
  assign bus.waddr      = out_q.addr;
  assign bus.wdata      = out_q.data;
  assign bus.fifo_count = count;
  assign bus.pend_hit1  = (bus.pend_raddr1 != '0) && (|hit1_v);
  assign bus.pend_hit2  = (bus.pend_raddr2 != '0) && (|hit2_v);
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: priority, FIFO fill/drain, kill, $0 and reset.
module tb_wb_write_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wb_write_arbiter_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  wb_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                     input logic ev, input logic [4:0] ea, input logic [31:0] ed);
    bus.pipe_we    = pwe;
    bus.pipe_waddr = pa;
    bus.pipe_wdata = pd;
    bus.ext_valid  = ev;
    bus.ext_waddr  = ea;
    bus.ext_wdata  = ed;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"}, 64'(bus.we), 64'd1);
    check({tag, ".waddr"}, 64'(bus.waddr), 64'(a));
    check({tag, ".wdata"}, 64'(bus.wdata), 64'(d));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle();
    bus.pend_raddr1 = 5'd5;
    bus.pend_raddr2 = 5'd0;

    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst.we", 64'(bus.we), 64'd0);
    check("rst.count", 64'(bus.fifo_count), 64'd0);
    check("rst.ready", 64'(bus.ext_ready), 64'd0);
    check("rst.waddr", 64'(bus.waddr), 64'd0);
    check("rst.wdata", 64'(bus.wdata), 64'd0);
    check("rst.hit1", 64'(bus.pend_hit1), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle.we", 64'(bus.we), 64'd0);
    check("idle.ready", 64'(bus.ext_ready), 64'd1);
    check("idle.count", 64'(bus.fifo_count), 64'd0);

    // single ext write r5 = 0x1234
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    tick();
    idle();
`ifdef WB_BYPASS_EN
    chk_wr("byp", 5'd5, 32'h1234);
    check("byp.count", 64'(bus.fifo_count), 64'd0);
    tick();
    check("byp.we_off", 64'(bus.we), 64'd0);
`else
    check("ext1.we0", 64'(bus.we), 64'd0);
    check("ext1.count", 64'(bus.fifo_count), 64'd1);
    check("ext1.hit1", 64'(bus.pend_hit1), 64'd1);
    tick();
    chk_wr("ext1", 5'd5, 32'h1234);
    check("ext1.count0", 64'(bus.fifo_count), 64'd0);
    check("ext1.hit1_off", 64'(bus.pend_hit1), 64'd0);
    tick();
    check("ext1.we_off", 64'(bus.we), 64'd0);
    check("ext1.hold", 64'(bus.waddr), 64'd5);
`endif

    // pipeline r1..r6 with ext r9, r10 pushed alongside
    for (int k = 1; k <= 6; k++) begin
      drv(1'b1, 5'(k), 32'h100 + 32'(k), k <= 2, (k == 1) ? 5'd9 : 5'd10,
          (k == 1) ? 32'hA : 32'hB);
      tick();
      chk_wr("pipe", 5'(k), 32'h100 + 32'(k));
      check("pipe.count", 64'(bus.fifo_count), (k == 1) ? 64'd1 : 64'd2);
    end
    idle();
    tick();
    chk_wr("drain9", 5'd9, 32'hA);
    check("drain9.count", 64'(bus.fifo_count), 64'd1);
    tick();
    chk_wr("drain10", 5'd10, 32'hB);
    check("drain10.count", 64'(bus.fifo_count), 64'd0);
    tick();
    check("drain.we_off", 64'(bus.we), 64'd0);

    // fill the FIFO behind a busy pipeline, fifth write waits for the first pop
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 5'd20, 32'h200 + 32'(k), 1'b1, 5'd11 + 5'(k), 32'h110 + 32'(k));
      tick();
      check("fill.count", 64'(bus.fifo_count), 64'(k + 1));
    end
    check("full.ready", 64'(bus.ext_ready), 64'd0);
    drv(1'b1, 5'd20, 32'h2FF, 1'b1, 5'd15, 32'hF);
    #1;
    check("full.ready2", 64'(bus.ext_ready), 64'd0);
    tick();
    check("full.count", 64'(bus.fifo_count), 64'd4);
    chk_wr("full.pipe", 5'd20, 32'h2FF);
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF);
    tick();
    chk_wr("pop11", 5'd11, 32'h110);
    check("pop11.count", 64'(bus.fifo_count), 64'd3);
    check("pop11.ready", 64'(bus.ext_ready), 64'd1);
    tick();
    idle();
    chk_wr("pop12", 5'd12, 32'h111);
    check("pop12.count", 64'(bus.fifo_count), 64'd3);
    tick();
    chk_wr("pop13", 5'd13, 32'h112);
    tick();
    chk_wr("pop14", 5'd14, 32'h113);
    tick();
    chk_wr("pop15", 5'd15, 32'hF);
    check("pop15.count", 64'(bus.fifo_count), 64'd0);

    // kill: queued r7=1 overtaken by pipeline r7=2
    bus.pend_raddr1 = 5'd7;
    drv(1'b1, 5'd20, 32'h300, 1'b1, 5'd7, 32'h1);
    tick();
    check("kill.count", 64'(bus.fifo_count), 64'd1);
    check("kill.hit_pre", 64'(bus.pend_hit1), 64'd1);
    drv(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("kill.pipe", 5'd7, 32'h2);
    check("kill.count1", 64'(bus.fifo_count), 64'd1);
    check("kill.hit_post", 64'(bus.pend_hit1), 64'd0);
    idle();
    tick();
    check("kill.we_idle", 64'(bus.we), 64'd0);
    check("kill.count0", 64'(bus.fifo_count), 64'd0);
    check("kill.final", 64'(bus.wdata), 64'h2);

    // same-edge kill of an entry being enqueued
    bus.pend_raddr2 = 5'd8;
    drv(1'b1, 5'd8, 32'h3, 1'b1, 5'd8, 32'h4);
    tick();
    chk_wr("kill2", 5'd8, 32'h3);
    check("kill2.count", 64'(bus.fifo_count), 64'd1);
    check("kill2.hit2", 64'(bus.pend_hit2), 64'd0);
    idle();
    tick();
    check("kill2.we_idle", 64'(bus.we), 64'd0);
    check("kill2.count0", 64'(bus.fifo_count), 64'd0);

    // $0 handling
    bus.pend_raddr1 = 5'd0;
    bus.pend_raddr2 = 5'd3;
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
    #1;
    check("r0.ready", 64'(bus.ext_ready), 64'd1);
    tick();
    check("r0.count", 64'(bus.fifo_count), 64'd0);
    check("r0.we", 64'(bus.we), 64'd0);
    drv(1'b1, 5'd20, 32'h400, 1'b1, 5'd3, 32'h33);
    tick();
    check("r3.count", 64'(bus.fifo_count), 64'd1);
    check("r3.hit2", 64'(bus.pend_hit2), 64'd1);
    check("r3.hit1_r0", 64'(bus.pend_hit1), 64'd0);
    drv(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("r3.drain", 5'd3, 32'h33);
    check("r3.count0", 64'(bus.fifo_count), 64'd0);
    check("r3.hit2_off", 64'(bus.pend_hit2), 64'd0);

    // reset with two entries queued
    bus.pend_raddr1 = 5'd21;
    drv(1'b1, 5'd20, 32'h500, 1'b1, 5'd21, 32'h21);
    tick();
    drv(1'b1, 5'd20, 32'h501, 1'b1, 5'd22, 32'h22);
    tick();
    check("mid.count", 64'(bus.fifo_count), 64'd2);
    check("mid.hit1", 64'(bus.pend_hit1), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.rst_count", 64'(bus.fifo_count), 64'd0);
    check("mid.rst_we", 64'(bus.we), 64'd0);
    check("mid.rst_ready", 64'(bus.ext_ready), 64'd0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    check("post.we", 64'(bus.we), 64'd0);
    check("post.count", 64'(bus.fifo_count), 64'd0);
    check("post.hit1", 64'(bus.pend_hit1), 64'd0);
    tick();
    check("post.we2", 64'(bus.we), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
